// File: rtl/axil_regfile_rd_sequencer.sv
// rtl/axil_regfile_rd_sequencer.sv - AXI-Lite window reader replaying registers as one AXI-Stream packet
module axil_regfile_rd_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int REG_NUM    = 1024
) (
  input  logic                  axil_clk,
  input  logic                  axil_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           word_num,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_OUT,
    S_FIN
  } state_t;

  localparam logic [31:0]           REG_NUM_W = 32'(REG_NUM);
  localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(STRB_WIDTH);

  state_t                  state_q, state_d;
  logic [31:0]             len_q, len_d;
  logic [31:0]             idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                    err_q, err_d;
  logic [31:0]             len_clamped;
  logic                    last_word;

  assign len_clamped = (word_num > REG_NUM_W) ? REG_NUM_W : word_num;
  assign last_word   = (idx_q == len_q - 32'd1);

  always_ff @(posedge axil_clk) begin
    if (axil_rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      araddr_q <= '0;
      tdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      araddr_q <= araddr_d;
      tdata_q  <= tdata_d;
      err_q    <= err_d;
    end
  end

  // The address register steps by one stride per accepted word, tracking base + idx*stride.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    araddr_d = araddr_q;
    tdata_d  = tdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          araddr_d = base_addr;
          len_d    = len_clamped;
          idx_d    = '0;
          err_d    = 1'b0;
          state_d  = (len_clamped == 32'd0) ? S_FIN : S_AR;
        end
      end
      S_AR: begin
        if (m_axil_arready) state_d = S_R;
      end
      S_R: begin
        if (m_axil_rvalid) begin
          tdata_d = m_axil_rdata;
          err_d   = err_q | (m_axil_rresp != 2'b00);
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (m_axis_tready) begin
          if (last_word) begin
            state_d = S_FIN;
          end else begin
            idx_d    = idx_q + 32'd1;
            araddr_d = araddr_q + STRIDE;
            state_d  = S_AR;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_FIN);
  assign err            = err_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = (state_q == S_AR);
  assign m_axil_rready  = (state_q == S_R);
  assign m_axis_tdata   = tdata_q;
  assign m_axis_tvalid  = (state_q == S_OUT);
  assign m_axis_tlast   = (state_q == S_OUT) && last_word;

endmodule

// File: tb/tb_axil_regfile_rd_sequencer.sv
// tb/tb_axil_regfile_rd_sequencer.sv - randomized model-checked bench for axil_regfile_rd_sequencer
module tb_axil_regfile_rd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] word_num = '0;
  logic        busy, done, err;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid, rready, tvalid, tlast;
  logic        arready = 1'b0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic [63:0] tdata;
  logic        tready = 1'b0;

  always #5 clk = ~clk;

  axil_regfile_rd_sequencer dut (
    .axil_clk(clk), .axil_rst(rst), .start(start), .base_addr(base_addr),
    .word_num(word_num), .busy(busy), .done(done), .err(err),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
    .m_axil_arready(arready), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
    .m_axil_rvalid(rvalid), .m_axil_rready(rready), .m_axis_tdata(tdata),
    .m_axis_tlast(tlast), .m_axis_tvalid(tvalid), .m_axis_tready(tready)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sdata(input logic [31:0] a);
    return {~a, a};
  endfunction

  // Slave register file and sink: random readiness, one pending read at most.
  int          duty = 100;
  logic [31:0] err_addr = 32'h1;
  bit          s_pend = 0;
  logic [31:0] s_addr = '0;

  initial begin
    bit ar_hs, r_hs, rst_s;
    logic [31:0] a_s;
    forever begin
      @(negedge clk);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      a_s   = araddr;
      rst_s = rst;
      @(posedge clk);
      #1;
      if (rst_s) begin
        s_pend = 0;
        rvalid = 1'b0;
      end else begin
        if (r_hs) begin
          rvalid = 1'b0;
          s_pend = 0;
        end
        if (ar_hs) begin
          s_pend = 1;
          s_addr = a_s;
        end
        if (s_pend && !rvalid && ($urandom_range(99) < duty)) begin
          rvalid = 1'b1;
          rdata  = sdata(s_addr);
          rresp  = (s_addr == err_addr) ? 2'b10 : 2'b00;
        end
      end
      arready = ($urandom_range(99) < duty);
      tready  = ($urandom_range(99) < duty);
    end
  end

  // Behavioural model: a job is (base, len); the packet is sdata(base + 8*i), i < len.
  int          cyc = 0;
  bit          m_active = 0, m_done_next = 0, m_err = 0;
  logic [31:0] m_base = '0;
  int          m_len = 0, m_ars = 0, m_rs = 0, m_beats = 0;
  int          start_cyc = 0, busy_rise_cyc = 0, done_cyc = 0, done_cnt = 0;
  int          ar_cyc = 0, tv_cyc = 0, tlast_cnt = 0;
  logic [31:0] ar_log[$];
  logic [31:0] tlo_log[$];
  bit          p_rst = 1, p_busy = 0, p_arvalid = 0, p_arready = 0, p_tvalid = 0, p_tready = 0, p_tlast = 0;
  logic [31:0] p_araddr = '0;
  logic [63:0] p_tdata = '0;

  always @(negedge clk) begin
    logic [31:0] ea;
    bit idle;
    cyc++;
    if (p_rst) begin
      chk({busy, done, err, arvalid, rready, tvalid, tlast} == 7'b0, "reset_ctrl",
          64'({busy, done, err, arvalid, rready, tvalid, tlast}), 64'h0);
      chk(araddr == 32'h0 && tdata == 64'h0, "reset_data", {araddr, tdata[31:0]}, 64'h0);
    end else begin
      chk(busy == (m_active || m_done_next), "busy", 64'(busy), 64'(m_active || m_done_next));
      chk(done == m_done_next, "done", 64'(done), 64'(m_done_next));
      chk(err == m_err, "err", 64'(err), 64'(m_err));
      chk(arprot == 3'b000, "arprot", 64'(arprot), 64'h0);
      chk(!(arvalid && tvalid), "ar_while_out", 64'({arvalid, tvalid}), 64'h0);
      if (arvalid) begin
        ea = m_base + 32'(m_ars) * 32'd8;
        chk(m_active && m_ars < m_len && m_rs == m_ars && m_beats == m_ars, "ar_outstanding",
            64'(m_ars), 64'(m_beats));
        chk(araddr == ea, "araddr", 64'(araddr), 64'(ea));
      end
      if (rready)
        chk(m_ars == m_rs + 1, "rready_pending", 64'(m_rs), 64'(m_ars - 1));
      if (p_arvalid && !p_arready)
        chk(arvalid && araddr == p_araddr, "ar_stable", 64'(araddr), 64'(p_araddr));
      if (p_tvalid && !p_tready)
        chk(tvalid && tdata == p_tdata && tlast == p_tlast, "t_stable", tdata, p_tdata);
      if (tvalid) begin
        ea = m_base + 32'(m_beats) * 32'd8;
        chk(m_rs == m_beats + 1, "tvalid_after_read", 64'(m_rs), 64'(m_beats + 1));
        chk(tdata == sdata(ea), "tdata", tdata, sdata(ea));
        chk(tlast == (m_beats == m_len - 1), "tlast", 64'(tlast), 64'(m_beats == m_len - 1));
      end
    end
    if (busy && !p_busy) busy_rise_cyc = cyc;
    if (done) begin done_cyc = cyc; done_cnt++; end
    if (arvalid) ar_cyc++;
    if (tvalid) tv_cyc++;
    if (rst) begin
      m_active = 0; m_done_next = 0; m_err = 0;
      m_ars = 0; m_rs = 0; m_beats = 0;
    end else begin
      idle = !m_active && !m_done_next;
      m_done_next = 0;
      if (arvalid && arready) begin m_ars++; ar_log.push_back(araddr); end
      if (rvalid && rready) begin m_rs++; if (rresp != 2'b00) m_err = 1; end
      if (tvalid && tready) begin
        m_beats++;
        tlo_log.push_back(tdata[31:0]);
        if (tlast) tlast_cnt++;
        if (m_beats == m_len) begin m_active = 0; m_done_next = 1; end
      end
      if (start && idle) begin
        m_base = base_addr;
        m_len = (word_num > 32'd1024) ? 1024 : int'(word_num);
        m_ars = 0; m_rs = 0; m_beats = 0; m_err = 0;
        start_cyc = cyc; ar_cyc = 0; tv_cyc = 0; tlast_cnt = 0;
        ar_log.delete(); tlo_log.delete();
        if (m_len == 0) m_done_next = 1; else m_active = 1;
      end
    end
    p_rst = rst; p_busy = busy;
    p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
    p_tvalid = tvalid; p_tready = tready; p_tdata = tdata; p_tlast = tlast;
  end

  task automatic wait_idle();
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk(0, "idle_timeout", 64'(busy), 64'h0);
  endtask

  task automatic kick(input logic [31:0] b, input logic [31:0] n);
    @(posedge clk); #1;
    base_addr = b; word_num = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    if (!got) chk(0, "done_timeout", 64'(done), 64'h1);
    @(negedge clk);
  endtask

  task automatic run_job(input logic [31:0] b, input logic [31:0] n);
    wait_idle();
    kick(b, n);
    wait_done();
  endtask

  initial begin
    int dc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_job(32'h100, 4);
    chk(done_cyc - busy_rise_cyc == 12, "lat4", 64'(done_cyc - busy_rise_cyc), 64'd12);
    chk(ar_log.size() == 4, "ar_count4", 64'(ar_log.size()), 64'd4);
    if (ar_log.size() == 4) begin
      chk(ar_log[0] == 32'h100 && ar_log[3] == 32'h118, "ar_seq4", {ar_log[0], ar_log[3]}, {32'h100, 32'h118});
      chk(ar_log[1] == 32'h108 && ar_log[2] == 32'h110, "ar_mid4", {ar_log[1], ar_log[2]}, {32'h108, 32'h110});
    end
    if (tlo_log.size() == 4)
      chk(tlo_log[3] == 32'h118 && tlo_log[0] == 32'h100, "tdata4", {tlo_log[0], tlo_log[3]}, {32'h100, 32'h118});
    chk(tlast_cnt == 1, "tlast_once", 64'(tlast_cnt), 64'd1);

    run_job(32'h40, 0);
    chk(done_cyc - start_cyc == 1, "len0_done", 64'(done_cyc - start_cyc), 64'd1);
    chk(ar_cyc == 0 && tv_cyc == 0, "len0_idle_bus", 64'(ar_cyc + tv_cyc), 64'd0);
    chk(err == 1'b0, "len0_err", 64'(err), 64'd0);

    run_job(32'h2000, 5000);
    chk(m_beats == 1024, "clamp_beats", 64'(m_beats), 64'd1024);
    chk(ar_log.size() > 0 && ar_log[$] == 32'h3FF8, "clamp_last_addr",
        64'(ar_log.size() > 0 ? ar_log[$] : 32'h0), 64'h3FF8);

    err_addr = 32'h508;
    run_job(32'h500, 3);
    chk(err == 1'b1 && m_beats == 3, "err_sticky", 64'({err, 4'(m_beats)}), 64'h13);
    err_addr = 32'h1;
    run_job(32'h600, 2);
    chk(err == 1'b0, "err_cleared", 64'(err), 64'd0);

    duty = 70;
    for (int j = 0; j < 10; j++) begin
      logic [31:0] b;
      logic [31:0] n;
      b = (j == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFF8);
      n = 32'($urandom_range(12, 1));
      err_addr = ($urandom_range(1) == 1) ? b + 32'($urandom_range(n - 1)) * 32'd8 : 32'h1;
      run_job(b, n);
      chk(m_beats == int'(n), "rand_beats", 64'(m_beats), 64'(n));
    end
    err_addr = 32'h1;

    wait_idle();
    kick(32'h800, 6);
    repeat (4) @(posedge clk);
    #1 base_addr = 32'h900; word_num = 2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    chk(m_beats == 6 && m_base == 32'h800, "start_ignored", 64'(m_beats), 64'd6);

    wait_idle();
    kick(32'hA00, 5);
    begin
      bit got = 0;
      for (int i = 0; i < 2000 && !got; i++) begin
        @(negedge clk);
        if (tvalid && m_beats >= 1) got = 1;
      end
      chk(got, "out_wait", 64'(got), 64'd1);
    end
    @(posedge clk); #1 rst = 1'b1;
    dc = done_cnt;
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk(done_cnt == dc, "no_done_on_reset", 64'(done_cnt), 64'(dc));

    duty = 100;
    run_job(32'hC00, 3);
    chk(m_beats == 3 && err == 1'b0, "recover", 64'(m_beats), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
